// File: rtl/as_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : as_result_fifo
// Brief    : Capture stage for as_4b results: derives {V,N,Z,C} flags, buffers
//            result+flags in a small FIFO and counts accepted operations.
// Revision : 1.0 - initial release
// ============================================================================
module as_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic                     in_a_msb,
    input  logic                     in_b_msb,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         op_count
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                ENT_W     = WIDTH + 4;
    localparam logic [PTR_W:0]    C_DEPTH   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    C_LVL_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             res_msb;
    logic             flag_v, flag_n, flag_z, flag_c;
    logic             push, pop;

    // Subtraction in as_4b is A + ~B + 1, so its carry-out is the inverse of borrow.
    always_comb begin
        res_msb = in_result[WIDTH-1];
        flag_z  = (in_result == '0);
        flag_n  = res_msb;
        flag_c  = in_mode ? ~in_carry : in_carry;
        if (in_mode) begin
            flag_v = (in_a_msb != in_b_msb) && (res_msb != in_a_msb);
        end else begin
            flag_v = (in_a_msb == in_b_msb) && (res_msb != in_a_msb);
        end
    end

    assign in_ready  = (level_q != C_DEPTH);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        op_count_d = op_count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {flag_v, flag_n, flag_z, flag_c, in_result};
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + C_LVL_ONE;
            2'b01:   level_d = level_q - C_LVL_ONE;
            default: level_d = level_q;
        endcase

        // Clear takes priority over a coincident push.
        if (cnt_clr) begin
            op_count_d = '0;
        end else if (push && (op_count_q != C_CNT_MAX)) begin
            op_count_d = op_count_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            op_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            op_count_q <= op_count_d;
        end
    end

    assign out_result = mem_q[rd_ptr_q][WIDTH-1:0];
    assign out_flags  = mem_q[rd_ptr_q][ENT_W-1:WIDTH];
    assign level      = level_q;
    assign op_count   = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_as_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_as_result_fifo
// Brief    : Self-checking bench for as_result_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_as_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_mode, in_a_msb, in_b_msb, in_carry, out_ready, cnt_clr;
    logic [3:0] in_result;
    logic       in_ready, out_valid, in_ready2, out_valid2;
    logic [3:0] out_result, out_flags, out_result2, out_flags2;
    logic [2:0] level, level2;
    logic [7:0] op_count;
    logic [1:0] op_count2;

    int         vecs = 0;
    int         errs = 0;
    logic [7:0] q[$];
    int         cnt8 = 0;
    int         cnt2 = 0;
    logic [7:0] cur_entry = 8'h00;

    always #5 clk = ~clk;

    as_result_fifo #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .in_result(in_result), .in_carry(in_carry), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .level(level), .cnt_clr(cnt_clr), .op_count(op_count)
    );

    as_result_fifo #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_mode(in_mode), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .in_result(in_result), .in_carry(in_carry), .out_valid(out_valid2),
        .out_ready(out_ready), .out_result(out_result2), .out_flags(out_flags2),
        .level(level2), .cnt_clr(cnt_clr), .op_count(op_count2)
    );

    // Reference: flags from integer arithmetic on the operands; entry = {V,N,Z,C,result}.
    function automatic logic [7:0] ref_entry(input logic [3:0] a, input logic [3:0] b, input logic mode);
        int ua, ub, sa, sb, u, s;
        logic [3:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        u  = mode ? ua - ub : ua + ub;
        s  = mode ? sa - sb : sa + sb;
        r  = u[3:0];
        c  = mode ? (ua < ub) : (u > 15);
        v  = (s > 7) || (s < -8);
        return {v, r[3], (r == 4'd0), c, r};
    endfunction

    // Emulates the upstream as_4b unit and records the expected entry.
    task automatic set_op(input logic [3:0] a, input logic [3:0] b, input logic mode);
        logic [4:0] t;
        t = mode ? ({1'b0, a} + {1'b0, ~b} + 5'd1) : ({1'b0, a} + {1'b0, b});
        in_mode   = mode;
        in_a_msb  = a[3];
        in_b_msb  = b[3];
        in_result = t[3:0];
        in_carry  = t[4];
        cur_entry = ref_entry(a, b, mode);
    endtask

    task automatic set_rand_op();
        set_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    // Advances one clock and updates the model from the inputs applied this cycle.
    task automatic tick();
        logic push, pop;
        logic [7:0] e;
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() > 0);
        e    = cur_entry;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (cnt_clr) begin
            cnt8 = 0;
            cnt2 = 0;
        end else if (push) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3) cnt2++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
        vecs++; if (op_count !== 8'd0) begin errs++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        vecs++; if ({out_result, out_flags} !== 8'h00) begin errs++; $display("FAIL reset_out_data: got %h want 00", {out_result, out_flags}); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        cnt8 = 0;
        cnt2 = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flags();
        logic [3:0] want_flags [3];
        logic [3:0] want_res [3];
        logic [7:0] h;
        out_ready = 1'b0;
        set_op(4'd3, 4'd5, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
        vecs++; if (out_result !== 4'b1000) begin errs++; $display("FAIL add_result: got %b want 1000", out_result); end
        vecs++; if (out_flags !== 4'b1100) begin errs++; $display("FAIL add_flags: got %b want 1100", out_flags); end
        vecs++; if (level !== 3'd1) begin errs++; $display("FAIL add_level: got %0d want 1", level); end
        vecs++; if (op_count !== 8'd1) begin errs++; $display("FAIL add_op_count: got %0d want 1", op_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        want_res   = '{4'b0010, 4'b0000, 4'b1110};
        want_flags = '{4'b0000, 4'b0010, 4'b0101};
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_op(4'd5, 4'd3, 1'b1);
                1:       set_op(4'd5, 4'd5, 1'b1);
                default: set_op(4'd3, 4'd5, 1'b1);
            endcase
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            vecs++; if (out_result !== want_res[i]) begin errs++; $display("FAIL sub%0d_result: got %b want %b", i, out_result, want_res[i]); end
            vecs++; if (out_flags !== want_flags[i]) begin errs++; $display("FAIL sub%0d_flags: got %b want %b", i, out_flags, want_flags[i]); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        for (int i = 0; i < 24; i++) begin
            set_rand_op();
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            h = q[0];
            vecs++; if ({out_flags, out_result} !== h) begin errs++; $display("FAIL rand_flags: got %h want %h", {out_flags, out_result}, h); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            vecs++; if (level !== 3'(q.size())) begin errs++; $display("FAIL rand_flags_level: got %0d want %0d", level, q.size()); end
        end
    endtask

    task automatic test_full();
        logic [7:0] h;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_rand_op();
            in_valid = 1'b1;
            vecs++; if (in_ready !== (q.size() < DEPTH)) begin errs++; $display("FAIL fill_in_ready: got %b want %b", in_ready, q.size() < DEPTH); end
            tick();
        end
        in_valid = 1'b0;
        vecs++; if (level !== 3'd4) begin errs++; $display("FAIL full_level: got %0d want 4", level); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h = q[0];
            vecs++; if (level !== 3'(4 - i)) begin errs++; $display("FAIL drain_level: got %0d want %0d", level, 4 - i); end
            vecs++; if ({out_flags, out_result} !== h) begin errs++; $display("FAIL drain_data: got %h want %h", {out_flags, out_result}, h); end
            tick();
        end
        out_ready = 1'b0;
        vecs++; if (level !== 3'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty: got level %0d valid %b want 0 0", level, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] h;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin set_rand_op(); tick(); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_rand_op();
            h = q[0];
            vecs++; if ({out_flags, out_result} !== h) begin errs++; $display("FAIL b2b_data: got %h want %h", {out_flags, out_result}, h); end
            tick();
            vecs++; if (level !== 3'd2) begin errs++; $display("FAIL b2b_level: got %0d want 2", level); end
        end
        out_ready = 1'b0;
        repeat (2) begin set_rand_op(); tick(); end
        out_ready = 1'b1;
        set_rand_op();
        tick();
        vecs++; if (level !== 3'd3) begin errs++; $display("FAIL full_pop_level: got %0d want 3", level); end
        vecs++; if (op_count !== 8'(cnt8)) begin errs++; $display("FAIL full_pop_count: got %0d want %0d", op_count, cnt8); end
        in_valid = 1'b0;
        while (q.size() > 0) begin
            h = q[0];
            vecs++; if ({out_flags, out_result} !== h) begin errs++; $display("FAIL b2b_drain: got %h want %h", {out_flags, out_result}, h); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rand_op();
            tick();
            vecs++; if (op_count2 !== 2'(cnt2)) begin errs++; $display("FAIL sat_count2: got %0d want %0d", op_count2, cnt2); end
        end
        vecs++; if (op_count2 !== 2'd3) begin errs++; $display("FAIL sat_final: got %0d want 3", op_count2); end
        vecs++; if (op_count !== 8'd5) begin errs++; $display("FAIL sat_count8: got %0d want 5", op_count); end
        cnt_clr = 1'b1;
        set_rand_op();
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        vecs++; if (op_count2 !== 2'd0 || op_count !== 8'd0) begin errs++; $display("FAIL clr_wins: got %0d/%0d want 0/0", op_count, op_count2); end
        while (q.size() > 0) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] h;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin set_rand_op(); tick(); end
        in_valid = 1'b0;
        vecs++; if (level !== 3'd3) begin errs++; $display("FAIL pre_rst_level: got %0d want 3", level); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        vecs++; if (level !== 3'd0) begin errs++; $display("FAIL arst_level: got %0d want 0", level); end
        vecs++; if (op_count !== 8'd0) begin errs++; $display("FAIL arst_op_count: got %0d want 0", op_count); end
        q.delete();
        cnt8 = 0;
        cnt2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vecs++; if (level !== 3'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL post_rst_idle: got level %0d ready %b want 0 1", level, in_ready); end
        set_rand_op();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        h = q[0];
        vecs++; if ({out_flags, out_result} !== h || level !== 3'd1) begin errs++; $display("FAIL post_rst_push: got %h lvl %0d want %h lvl 1", {out_flags, out_result}, level, h); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] h;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cnt_clr   = ($urandom_range(0, 31) == 0);
            set_rand_op();
            vecs++; if (in_ready !== (q.size() < DEPTH)) begin errs++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, q.size() < DEPTH); end
            vecs++; if (out_valid !== (q.size() > 0)) begin errs++; $display("FAIL rnd_out_valid: got %b want %b", out_valid, q.size() > 0); end
            vecs++; if (level !== 3'(q.size())) begin errs++; $display("FAIL rnd_level: got %0d want %0d", level, q.size()); end
            vecs++; if (op_count !== 8'(cnt8) || op_count2 !== 2'(cnt2)) begin errs++; $display("FAIL rnd_count: got %0d/%0d want %0d/%0d", op_count, op_count2, cnt8, cnt2); end
            if (q.size() > 0) begin
                h = q[0];
                vecs++; if ({out_flags, out_result} !== h) begin errs++; $display("FAIL rnd_head: got %h want %h", {out_flags, out_result}, h); end
            end
            tick();
        end
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_mode = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0; in_result = 4'd0; in_carry = 1'b0;
        test_reset();
        test_flags();
        test_full();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/as_result_fifo.md
Name: as_result_fifo

Overview:
- Downstream capture stage for the 4-bit add/subtract unit `as_4b`.
- Each cycle an upstream sequencer presents an `as_4b` result with `in_valid`.
- This block derives status flags and buffers result plus flags in a small FIFO.
- A consumer drains the FIFO over a valid/ready handshake. A saturating count of accepted operations is also kept.

Parameters:
- WIDTH, 4, result width; must match as_4b.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a result this cycle.
- in_ready  output  1  block can accept an entry; equals !full.
- in_mode  input  1  as_4b mode: 0 = add A+B, 1 = subtract A-B.
- in_a_msb  input  1  A[WIDTH-1] of the operation.
- in_b_msb  input  1  B[WIDTH-1] of the operation.
- in_result  input  WIDTH  as_4b result.
- in_carry  input  1  as_4b carry_out.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_result  output  WIDTH  head result.
- out_flags  output  4  head flags {V,N,Z,C}.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- cnt_clr  input  1  synchronous clear of op_count.
- op_count  output  CNT_W  number of accepted entries, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers = 0, level = 0, out_valid = 0, in_ready = 1, op_count = 0. out_result and out_flags = 0.
- Reset mid-operation discards all buffered entries immediately. No entry is accepted on the cycle rst_n deasserts unless rst_n is already high at that clk edge.
- Push: in_valid & in_ready at a clk edge writes one entry. Pop: out_valid & out_ready at a clk edge removes the head.
- Flags are computed combinationally from the inputs at push time and stored with the entry:
  - Z = (in_result == 0).
  - N = in_result[WIDTH-1].
  - C: mode 0 -> in_carry (unsigned carry out). Mode 1 -> ~in_carry, i.e. borrow, because as_4b subtracts as A + ~B + 1.
  - V, mode 0: (in_a_msb == in_b_msb) & (in_result[WIDTH-1] != in_a_msb).
  - V, mode 1: (in_a_msb != in_b_msb) & (in_result[WIDTH-1] != in_a_msb).
- Latency: an entry pushed into an empty FIFO appears on out_valid/out_result/out_flags the next cycle. Outputs are registered storage read by the read pointer; there is no combinational in->out path.
- out_result and out_flags hold stable while out_valid & !out_ready.
- When out_valid = 0, out_result and out_flags hold the last read location (don't-care for checking).
- Full (level == DEPTH): in_ready = 0 and in_valid is ignored, with no overwrite. A same-cycle pop while full does NOT allow a push that cycle; in_ready depends only on level.
- Empty (level == 0): out_valid = 0 and out_ready is ignored; the pointers do not move.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. level is tracked explicitly, not derived from pointer difference alone.
- op_count increments on each push and saturates at 2^CNT_W-1.
- cnt_clr clears op_count to 0. If a push coincides with cnt_clr, op_count becomes 0; clear wins.
- level and op_count are registered and reflect state after the last edge.

Test Plan:
1. Reset, then push {mode 0, a_msb 0, b_msb 0, result 4'b1000, carry 0} (3+5). Next cycle: out_valid = 1, out_result = 1000, out_flags = {V1,N1,Z0,C0}, level = 1, op_count = 1.
2. Push mode 1, a_msb 0, b_msb 0, result 0010, carry 1 (5-3) -> flags {0,0,0,0}. Push mode 1, result 0000, carry 1 (5-5) -> flags Z = 1, C = 0. Push mode 1, a_msb 0, b_msb 0, result 1110, carry 0 (3-5) -> C = 1 (borrow), N = 1, V = 0.
3. Hold out_ready = 0 and push 5 entries back-to-back. Entries 1-4 are accepted, in_ready = 0 after the 4th, the 5th is held by upstream, level = 4. Then drain with out_ready = 1 -> outputs come in order and level counts 4,3,2,1,0.
4. At level 2, assert push and pop together for 6 cycles -> level stays 2, data order preserved across pointer wrap. At level 4, assert out_ready and in_valid together -> pop only, level = 3.
5. Set CNT_W = 2 and push 5 entries -> op_count saturates at 3. Pulse cnt_clr together with a push -> op_count = 0.
6. With level = 3, assert rst_n = 0 between clock edges -> out_valid = 0, level = 0, op_count = 0 immediately, without waiting for a clk edge. After release, the FIFO behaves as empty.
